// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and helpers for the nibble-serial add/subtract controller.
package arith_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic int nibbles(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle between requester, adder controller and consumer.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Overflow;

    modport master (
        output in_valid, A, B, Cin, Sub, out_ready,
        input  in_ready, out_valid, Sum, Cout, Overflow
    );

    modport slave (
        input  in_valid, A, B, Cin, Sub, out_ready,
        output in_ready, out_valid, Sum, Cout, Overflow
    );
endinterface

// File: rtl/full_adder_4bit.sv
// Four-bit adder slice with carry in/out; the only arithmetic in the serial adder.
module full_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);
endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract computed one nibble per clock through a single 4-bit slice.
module nibble_serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int NIBBLES = nibbles(WIDTH);
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   bx_q, bx_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic [NIBBLES-1:0] nib_we;
    logic [3:0]         fa_a, fa_b, fa_sum;
    logic               fa_cout;

    assign fa_a = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
    assign fa_b = bx_q[NIBBLE_W*idx_q +: NIBBLE_W];

    full_adder_4bit u_fa (
        .a    (fa_a),
        .b    (fa_b),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        for (int i = 0; i < NIBBLES; i++) begin
            nib_we[i] = (state_q == RUN) && (idx_q == IDX_W'(i));
        end
    end

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        bx_d    = bx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        for (int i = 0; i < NIBBLES; i++) begin
            if (nib_we[i]) sum_d[NIBBLE_W*i +: NIBBLE_W] = fa_sum;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Subtraction is A + ~B with the carry seeded by the inverted borrow-in.
                    a_d     = bus.A;
                    bx_d    = bus.B ^ {WIDTH{bus.Sub}};
                    carry_d = bus.Cin ^ bus.Sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = fa_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = fa_cout;
                    ovf_d   = (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (fa_sum[3] != a_q[WIDTH-1]);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: operand registers are always rewritten on accept before use, so they carry no reset.
    always_ff @(posedge clk) begin
        a_q  <= a_d;
        bx_q <= bx_d;
    end

    assign bus.in_ready  = rst_n && (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.Sum       = sum_q;
    assign bus.Cout      = cout_q;
    assign bus.Overflow  = ovf_q;

endmodule
